// File: rtl/branch_predict_unit.sv
// Branch resolution and 2-bit BHT dynamic prediction with registered flush/redirect.
// Fetch: f_valid/f_pc -> f_pred_taken. Execute: e_* -> e_taken, flush, redirect_pc.
// Optional counters stat_branches/stat_mispred built only when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int         XLEN     = 32,
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            e_valid,
  input  logic            e_branch,
  input  logic            e_jump,
  input  logic            e_is_jalr,
  input  logic [2:0]      e_funct3,
  input  logic            e_zero,
  input  logic            e_lts,
  input  logic            e_ltu,
  input  logic [XLEN-1:0] e_pc,
  input  logic            e_pred_taken,
  input  logic [XLEN-1:0] e_target,
  output logic            e_taken,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bht_q [ENTRIES];
  logic [1:0]          bht_d [ENTRIES];
  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] e_idx;
  logic                br_taken;
  logic                legal;
  logic                upd;
  logic                mis;
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     redirect_q, redirect_d;
  logic [1:0]          cnt;
  logic                unused_f_pc;

  assign f_idx        = f_pc[IDX_BITS+1:2];
  assign e_idx        = e_pc[IDX_BITS+1:2];
  assign unused_f_pc  = ^{f_pc[1:0], f_pc[XLEN-1:IDX_BITS+2]};
  assign f_pred_taken = f_valid & bht_q[f_idx][1];

  always_comb begin
    br_taken = 1'b0;
    legal    = 1'b1;
    case (e_funct3)
      3'b000:  br_taken = e_zero;
      3'b001:  br_taken = ~e_zero;
      3'b100:  br_taken = e_lts;
      3'b101:  br_taken = ~e_lts;
      3'b110:  br_taken = e_ltu;
      3'b111:  br_taken = ~e_ltu;
      default: legal    = 1'b0;
    endcase
  end

  assign e_taken = e_valid & (e_jump | (e_branch & br_taken));
  assign upd     = e_valid & e_branch & legal;

  // jalr targets are never predicted, so every jalr redirects.
  assign mis = e_valid & (
                 (e_branch & (e_taken != e_pred_taken)) |
                 (e_jump & ~e_is_jalr & ~e_pred_taken) |
                 (e_jump & e_is_jalr));

  always_comb begin
    bht_d = bht_q;
    cnt   = bht_q[e_idx];
    if (upd) begin
      if (br_taken) begin
        if (cnt != 2'd3) cnt = cnt + 2'd1;
      end else begin
        if (cnt != 2'd0) cnt = cnt - 2'd1;
      end
      bht_d[e_idx] = cnt;
    end
  end

  always_comb begin
    flush_d    = mis;
    redirect_d = redirect_q;
    if (mis) redirect_d = e_taken ? e_target : e_pc + XLEN'(4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_INIT;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      bht_q      <= bht_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

`ifdef BPU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (e_valid & e_branch & (stat_br_q != 32'hFFFF_FFFF))
      stat_br_d = stat_br_q + 32'd1;
    if (mis & (stat_mis_q != 32'hFFFF_FFFF))
      stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mis_q;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit.
// Hand-computed vectors for prediction, resolution, flush and counters.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        e_valid, e_branch, e_jump, e_is_jalr;
  logic [2:0]  e_funct3;
  logic        e_zero, e_lts, e_ltu;
  logic [31:0] e_pc;
  logic        e_pred_taken;
  logic [31:0] e_target;
  logic        e_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispred;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .e_valid(e_valid), .e_branch(e_branch), .e_jump(e_jump),
    .e_is_jalr(e_is_jalr), .e_funct3(e_funct3), .e_zero(e_zero),
    .e_lts(e_lts), .e_ltu(e_ltu), .e_pc(e_pc),
    .e_pred_taken(e_pred_taken), .e_target(e_target),
    .e_taken(e_taken), .flush(flush), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    e_valid = 0; e_branch = 0; e_jump = 0; e_is_jalr = 0;
    e_funct3 = 3'b000; e_zero = 0; e_lts = 0; e_ltu = 0;
    e_pc = '0; e_pred_taken = 0; e_target = '0;
  endtask

  task automatic run(input string tag, input logic v, br, jp, jr,
                     input logic [2:0] f3, input logic z, lt, lu,
                     input logic [31:0] pc, tgt, input logic pred,
                     input logic xt, xf, input logic [31:0] xr);
    e_valid = v; e_branch = br; e_jump = jp; e_is_jalr = jr;
    e_funct3 = f3; e_zero = z; e_lts = lt; e_ltu = lu;
    e_pc = pc; e_target = tgt; e_pred_taken = pred;
    #1;
    check({tag, ".taken"}, e_taken, xt);
    @(posedge clk); #1;
    check({tag, ".flush"}, flush, xf);
    if (xf) check({tag, ".redir"}, redirect_pc, xr);
    idle();
  endtask

  initial begin
    reset = 1; f_valid = 0; f_pc = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.flush", flush, 0);
    check("rst.redir", redirect_pc, 0);
    check("rst.sb", stat_branches, 0);
    check("rst.sm", stat_mispred, 0);
    reset = 0;
    f_valid = 1; f_pc = 32'h40;
    #1;
    check("init.pred", f_pred_taken, 0);

    run("beq0", 1,1,0,0, 3'b000, 1,0,0, 32'h40, 32'h80, 0, 1,1, 32'h80);
    check("beq0.pred", f_pred_taken, 1);
    @(posedge clk); #1;
    check("beq0.pulse", flush, 0);

    for (int i = 0; i < 6; i++)
      run("beqT", 1,1,0,0, 3'b000, 1,0,0, 32'h40, 32'h80, 1, 1,0, 0);
    run("bneN1", 1,1,0,0, 3'b001, 1,0,0, 32'h40, 32'h80, 1, 0,1, 32'h44);
    check("sat.pred2", f_pred_taken, 1);
    run("bneN2", 1,1,0,0, 3'b001, 1,0,0, 32'h40, 32'h80, 1, 0,1, 32'h44);
    check("sat.pred1", f_pred_taken, 0);

    run("bltu", 1,1,0,0, 3'b110, 0,1,0, 32'h80, 32'h90, 0, 0,0, 0);
    run("bge",  1,1,0,0, 3'b101, 0,0,0, 32'h80, 32'h90, 1, 1,0, 0);
    run("blt",  1,1,0,0, 3'b100, 0,1,0, 32'h80, 32'h90, 1, 1,0, 0);
    run("bgeu", 1,1,0,0, 3'b111, 0,0,1, 32'h80, 32'h90, 0, 0,0, 0);
    run("bneT", 1,1,0,0, 3'b001, 0,0,0, 32'h80, 32'h90, 1, 1,0, 0);
    run("beqN", 1,1,0,0, 3'b000, 0,0,0, 32'h80, 32'h90, 0, 0,0, 0);

    run("beqC", 1,1,0,0, 3'b000, 1,0,0, 32'hC0, 32'h200, 0, 1,1, 32'h200);
    run("rsv2", 1,1,0,0, 3'b010, 1,1,1, 32'hC0, 32'h200, 1, 0,1, 32'hC4);
    run("rsv3", 1,1,0,0, 3'b011, 1,1,1, 32'hC0, 32'h200, 0, 0,0, 0);
    f_pc = 32'hC0;
    #1;
    check("rsv.noupd", f_pred_taken, 1);

    run("jalr", 1,0,1,1, 3'b000, 0,0,0, 32'hFFFF_FFFC, 32'h100, 1,
        1,1, 32'h100);
    f_pc = 32'hFFFF_FFFC;
    #1;
    check("jalr.noupd", f_pred_taken, 0);
    run("wrap", 1,1,0,0, 3'b000, 0,0,0, 32'hFFFF_FFFC, 32'h100, 1,
        0,1, 32'h0);
    run("jalN", 1,0,1,0, 3'b000, 0,0,0, 32'h10, 32'h300, 0, 1,1, 32'h300);
    run("jalP", 1,0,1,0, 3'b000, 0,0,0, 32'h10, 32'h300, 1, 1,0, 0);
    run("inval", 0,1,0,0, 3'b000, 1,0,0, 32'h40, 32'h80, 0, 0,0, 0);

    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 10; i++)
      run("stat", 1,1,0,0, 3'b000, 1,0,0, 32'h100, 32'h180,
          (i < 3) ? 1'b0 : 1'b1, 1, (i < 3) ? 1'b1 : 1'b0, 32'h180);
`ifdef BPU_STATS_EN
    check("stat.br", stat_branches, 10);
    check("stat.mis", stat_mispred, 3);
`else
    check("stat.br", stat_branches, 0);
    check("stat.mis", stat_mispred, 0);
`endif

    run("pre", 1,1,0,0, 3'b000, 1,0,0, 32'h100, 32'h180, 0, 1,1, 32'h180);
    f_pc = 32'h100;
    reset = 1;
    #1;
    check("midrst.flush", flush, 0);
    check("midrst.redir", redirect_pc, 0);
    check("midrst.sb", stat_branches, 0);
    check("midrst.sm", stat_mispred, 0);
    check("midrst.pred", f_pred_taken, 0);
    @(posedge clk); #1;
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
